uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver outputs (rx_data, rx_done, parity_error, framing_error) and a byte consumer.
- Captures each received byte together with its error tags into a FIFO.
- Presents the head entry on a valid/ready stream.
- Reports fill level, almost-full and a sticky overrun flag, so the consumer need not service every rx_done pulse in the cycle it occurs.

Parameters:
- DEPTH, 16: number of entries; power of 2, minimum 2.
- AF_THRESH, 12: almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- rx_data, input, 8: received byte; sampled only when rx_done=1.
- rx_done, input, 1: one-cycle pulse per received byte = push request.
- parity_error, input, 1: parity tag; sampled with rx_done.
- framing_error, input, 1: framing tag; sampled with rx_done.
- m_data, output, 8: head byte; 0 when m_valid=0.
- m_perr, output, 1: head entry parity tag; 0 when m_valid=0.
- m_ferr, output, 1: head entry framing tag; 0 when m_valid=0.
- m_valid, output, 1: head entry available.
- m_ready, input, 1: consumer accepts head; pop = m_valid & m_ready.
- level, output, $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- almost_full, output, 1: level >= AF_THRESH.
- overrun, output, 1: sticky; a byte was lost because the FIFO was full.
- clr_overrun, input, 1: synchronous clear of overrun.

Behaviour:
- Reset (rst=0, async):
  - wr_ptr, rd_ptr and level = 0.
  - m_valid, almost_full and overrun = 0.
  - m_data, m_perr and m_ferr = 0.
  - Storage array not reset.
  - Reset mid-stream discards all contents; no partial entry survives.
- Storage: DEPTH x 10-bit entries {framing_error, parity_error, rx_data}.
- Pointers: log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally. Full/empty derive from level, not pointer compare.
- Push: rx_done=1 and (level<DEPTH or pop in same cycle).
  - Writes mem[wr_ptr]; wr_ptr+1 at the next edge.
- Pop: m_valid & m_ready; rd_ptr+1 at the next edge.
- First-word fall-through: m_valid = (level!=0); m_data/m_perr/m_ferr = mem[rd_ptr] fields, gated to 0 when empty.
- Latency: rx_done in cycle N on an empty FIFO -> m_valid=1 with that byte in cycle N+1. No same-cycle bypass.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- almost_full: registered-consistent with level; updates in the same cycle level changes.
- Boundary conditions:
  - Empty + push + m_ready=1: no pop (m_valid=0). Byte stored; level 0->1.
  - Full + push + pop: both occur. Level stays DEPTH; no overrun.
  - Full + push, no pop: byte dropped. Pointers and level unchanged; overrun=1 from the next cycle.
  - overrun stays 1 until a cycle with clr_overrun=1. If a new overrun event coincides with clr_overrun, overrun stays 1 (set wins).
  - rx_done held high for multiple cycles: each cycle is a separate push (the receiver guarantees single-cycle pulses).
  - m_ready with m_valid=0: ignored.
- Error tags are stored, not acted on; bytes with errors are queued normally unless the optional feature is enabled.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_DROP_EN.
- Defined:
  - rx_done with parity_error=1 or framing_error=1 does not push; the byte is discarded.
  - Level is unchanged and overrun is unaffected.
  - An extra output err_drop_cnt (8 bits) counts discarded bytes; it saturates at 255 and resets to 0.
  - m_perr/m_ferr are tied to 0.
- Undefined:
  - Errored bytes are queued with their tags as described above.
  - err_drop_cnt port is absent.

Test Plan:
- Single byte: rx_done with rx_data=8'hA5, no errors, m_ready=0 -> next cycle m_valid=1, m_data=A5, level=1. Then m_ready=1 for one cycle -> m_valid=0, level=0, m_data=0.
- Fill and order: push 16 bytes 0x00..0x0F, m_ready=0 -> level=16; almost_full rises on the 12th push. Drain with m_ready=1 -> bytes read back 0x00..0x0F in order.
- Overrun: FIFO full, push 8'h55 with m_ready=0 -> level stays 16, overrun=1, 0x55 never appears on the output. clr_overrun=1 -> overrun=0 the next cycle.
- Full with simultaneous push/pop: FIFO full, rx_done=1 with rx_data=8'hC3 and m_ready=1 -> head popped, level stays 16, overrun stays 0. After 15 further pops, C3 is at the head.
- Error tag and reset: push 8'h3C with framing_error=1 -> m_ferr=1, m_perr=0 at the head (macro off), or level stays 0 and err_drop_cnt=1 (macro on). Assert rst=0 with 5 entries queued -> level=0, m_valid=0, overrun=0 immediately.
- Wrap-around: push/pop 40 bytes with m_ready toggled every other cycle -> output sequence identical to input; level never exceeds DEPTH; no overrun.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive-side buffer between a UART receiver and a byte consumer. Each
//   rx_done pulse queues {framing_error, parity_error, rx_data}. The head
//   entry is presented first-word-fall-through on a valid/ready stream. The
//   block also reports fill level, almost-full and a sticky overrun flag.
//
// Parameters:
//   DEPTH      number of entries (power of 2, >= 2)
//   AF_THRESH  almost_full asserts when level >= AF_THRESH (1..DEPTH)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   rx_data        received byte, sampled with rx_done
//   rx_done        push request (one-cycle pulse per byte)
//   parity_error   parity tag, sampled with rx_done
//   framing_error  framing tag, sampled with rx_done
//   m_data         head byte (0 when empty)
//   m_perr         head parity tag (0 when empty)
//   m_ferr         head framing tag (0 when empty)
//   m_valid        head entry available
//   m_ready        consumer accepts the head entry
//   level          number of stored entries, 0..DEPTH
//   almost_full    level >= AF_THRESH
//   overrun        sticky: a byte was lost because the FIFO was full
//   clr_overrun    synchronous clear of overrun
//   err_drop_cnt   saturating count of discarded errored bytes
//                  (present only with UART_RX_FIFO_ERR_DROP_EN)
//
// Optional feature macro: UART_RX_FIFO_ERR_DROP_EN
//   When defined, bytes tagged with a parity or framing error are discarded
//   instead of queued, counted in err_drop_cnt, and m_perr/m_ferr read 0.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = 12,
  localparam int PW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          parity_error,
  input  logic          framing_error,
  output logic [7:0]    m_data,
  output logic          m_perr,
  output logic          m_ferr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          overrun,
  input  logic          clr_overrun
`ifdef UART_RX_FIFO_ERR_DROP_EN
  ,
  output logic [7:0]    err_drop_cnt
`endif
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

  // Storage: {framing_error, parity_error, rx_data}; intentionally not reset.
  logic [9:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          af_q,     af_d;
  logic          ovr_q,    ovr_d;

  logic          full;
  logic          empty;
  logic          rx_err;
  logic          rx_accept;  // rx_done that is a candidate for queuing
  logic          push;
  logic          pop;
  logic          drop_full;  // candidate byte lost because there is no room
  logic [9:0]    head;

  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign rx_err = parity_error | framing_error;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign rx_accept = rx_done & ~rx_err;
`else
  assign rx_accept = rx_done;
`endif

  assign pop       = ~empty & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = rx_accept & (~full | pop);
  assign drop_full = rx_accept & full & ~pop;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovr_d    = ovr_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps naturally at DEPTH
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Clear first so a coinciding overrun event keeps the flag set.
    if (clr_overrun) ovr_d = 1'b0;
    if (drop_full)   ovr_d = 1'b1;

    af_d = (level_d >= AF_L);
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {framing_error, parity_error, rx_data};
  end

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (rx_done && rx_err && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= 8'd0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign err_drop_cnt = drop_cnt_q;
`endif

  // ---------------------------------------------------------------------
  // First-word-fall-through head: read is combinational off rd_ptr, so a
  // byte written in cycle N is visible in cycle N+1 with no bypass path.
  // ---------------------------------------------------------------------
  assign head    = mem[rd_ptr_q];
  assign m_valid = ~empty;
  assign m_data  = empty ? 8'd0 : head[7:0];

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign m_perr  = 1'b0;
  assign m_ferr  = 1'b0;
`else
  assign m_perr  = empty ? 1'b0 : head[8];
  assign m_ferr  = empty ? 1'b0 : head[9];
`endif

  assign level       = level_q;
  assign almost_full = af_q;
  assign overrun     = ovr_q;

endmodule
